// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters (master) and the arbiter (slave).
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  // Handshake: req[i] rises when requester i wants the resource and stays high
  // until it is done; the resource belongs to i while gnt[i]=1. gnt_id is only
  // meaningful while gnt_valid=1; preempt marks the cycle a grant was taken away.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             gnt_valid;
  logic             preempt;
  arb_state_t       state_dbg;
  logic [IDX_W-1:0] ptr_dbg;

  modport master (
    output req,
    input  gnt, gnt_id, gnt_valid, preempt, state_dbg, ptr_dbg
  );

  modport slave (
    input  req,
    output gnt, gnt_id, gnt_valid, preempt, state_dbg, ptr_dbg
  );

endinterface

// File: rtl/rr_prio_enc_4.sv
// Rotating-priority 4:2 encoder: first set bit of req searching from ptr upward, mod 4.
module rr_prio_enc_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   k;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign dbl = {req, req};
  assign rot = N_REQ'(dbl >> ptr);

  always_comb begin
    k = '0;
    if (rot[0])      k = 2'd0;
    else if (rot[1]) k = 2'd1;
    else if (rot[2]) k = 2'd2;
    else if (rot[3]) k = 2'd3;
  end

  assign sel = k + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a per-owner hold limit and
// registered one-hot / encoded grant outputs.
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
)(
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave arb
);

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;

  logic [N_REQ-1:0] enc_req;
  logic [IDX_W-1:0] enc_ptr;
  logic [IDX_W-1:0] enc_sel;
  logic             enc_any;
  logic             expire;

  // While granted, the owner is masked out and the search starts just past it,
  // so one encoder serves both release and hold-limit hand-over.
  always_comb begin
    enc_req = arb.req;
    enc_ptr = ptr_q;
    if (state_q == GRANT) begin
      enc_req = arb.req & ~onehot(gnt_id_q);
      enc_ptr = gnt_id_q + 2'd1;
    end
  end

  rr_prio_enc_4 u_enc (
    .req (enc_req),
    .ptr (enc_ptr),
    .sel (enc_sel),
    .any (enc_any)
  );

  assign expire = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d  = GRANT;
          gnt_d    = onehot(enc_sel);
          gnt_id_d = enc_sel;
          valid_d  = 1'b1;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (!arb.req[gnt_id_q]) begin
          ptr_d  = enc_ptr;
          hold_d = '0;
          if (enc_any) begin
            gnt_d    = onehot(enc_sel);
            gnt_id_d = enc_sel;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            valid_d  = 1'b0;
          end
        end else if (expire) begin
          // A lone owner just restarts its tenure; nobody else is waiting.
          hold_d = '0;
          if (enc_any) begin
            ptr_d     = enc_ptr;
            gnt_d     = onehot(enc_sel);
            gnt_id_d  = enc_sel;
            preempt_d = 1'b1;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  assign arb.gnt       = gnt_q;
  assign arb.gnt_id    = gnt_id_q;
  assign arb.gnt_valid = valid_q;
  assign arb.preempt   = preempt_q;
  assign arb.state_dbg = state_q;
  assign arb.ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed and random checks of rr_arbiter_4 against a cycle-level round-robin model.
module tb_rr_arbiter_4;
  import rr_arb_pkg::*;

  localparam int MAX_HOLD     = 8;
  localparam int STARVE_BOUND = 3 * MAX_HOLD + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_4_if arb_if ();

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb_if.slave)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  int   m_ptr;
  int   m_owner;
  int   m_tenure;
  logic m_preempt;

  // {preempt, ptr[1:0], valid, gnt_id[1:0], gnt[3:0]}
  logic [9:0] exp_q[$];
  int wait_cnt[4];
  int max_wait;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  // m_tenure = how many cycles the owner will have held the grant during the
  // cycle being evaluated (1 on its first granted cycle).
  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    m_preempt = 1'b0;
    if (m_owner < 0) begin
      m_owner  = pick(r, m_ptr);
      m_tenure = 1;
    end else if (!r[m_owner]) begin
      m_ptr    = (m_owner + 1) % 4;
      m_owner  = pick(r, m_ptr);
      m_tenure = 1;
    end else if (MAX_HOLD != 0 && m_tenure == MAX_HOLD) begin
      others = r;
      others[m_owner] = 1'b0;
      m_tenure = 1;
      if (others != 4'b0000) begin
        m_ptr     = (m_owner + 1) % 4;
        m_owner   = pick(others, m_ptr);
        m_preempt = 1'b1;
      end
    end else begin
      m_tenure++;
    end
  endtask

  function automatic logic [9:0] model_pack();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return {m_preempt, 2'(m_ptr), (m_owner >= 0), 2'(m_owner >= 0 ? m_owner : 0), g};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [3:0] r);
    logic [9:0] e;
    arb_if.req = r;
    model_step(r);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt", 8'(arb_if.gnt), 8'(e[3:0]));
    chk("gnt_valid", 8'(arb_if.gnt_valid), 8'(e[6]));
    if (e[6]) chk("gnt_id", 8'(arb_if.gnt_id), 8'(e[5:4]));
    chk("preempt", 8'(arb_if.preempt), 8'(e[9]));
    chk("ptr", 8'(arb_if.ptr_dbg), 8'(e[8:7]));
    chk("state", 8'(arb_if.state_dbg), e[6] ? 8'(GRANT) : 8'(IDLE));
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !arb_if.gnt[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  // Pulls rst_n low between edges, checks the immediate clear, holds two edges.
  task automatic reset_mid(input logic [3:0] r);
    arb_if.req = r;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 8'(arb_if.gnt), 8'h00);
    chk("rst_valid", 8'(arb_if.gnt_valid), 8'h00);
    chk("rst_id", 8'(arb_if.gnt_id), 8'h00);
    chk("rst_preempt", 8'(arb_if.preempt), 8'h00);
    chk("rst_ptr", 8'(arb_if.ptr_dbg), 8'h00);
    chk("rst_state", 8'(arb_if.state_dbg), 8'(IDLE));
    m_ptr = 0; m_owner = -1; m_tenure = 0; m_preempt = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_gnt", 8'(arb_if.gnt), 8'h00);
      chk("rst_hold_valid", 8'(arb_if.gnt_valid), 8'h00);
    end
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int order[$];
    int exp_order[5];
    int last_id;
    int gaps;
    int n_pre;
    logic [3:0] r;
    logic [3:0] rnd_req;

    exp_order = '{0, 1, 2, 3, 0};
    max_wait  = 0;
    arb_if.req = 4'b0000;
    rst_n = 1'b0;

    // 1: reset with all requesting, then idle
    reset_mid(4'b1111);
    for (int k = 0; k < 3; k++) cycle(4'b0000);
    chk("t1_idle_gnt", 8'(arb_if.gnt), 8'h00);

    // 2: single request, release after 5 cycles
    cycle(4'b0100);
    chk("t2_gnt", 8'(arb_if.gnt), 8'b0100);
    chk("t2_id", 8'(arb_if.gnt_id), 8'd2);
    for (int k = 0; k < 4; k++) cycle(4'b0100);
    cycle(4'b0000);
    chk("t2_rel_gnt", 8'(arb_if.gnt), 8'h00);
    chk("t2_rel_ptr", 8'(arb_if.ptr_dbg), 8'd3);

    // 3: rotation, each owner drops its bit on its second granted cycle
    reset_mid(4'b0000);
    last_id = -1;
    gaps = 0;
    for (int k = 0; k < 10; k++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_tenure == 2) r[m_owner] = 1'b0;
      cycle(r);
      if (!arb_if.gnt_valid) gaps++;
      else if (int'(arb_if.gnt_id) != last_id) begin
        last_id = int'(arb_if.gnt_id);
        order.push_back(last_id);
      end
    end
    chk("t3_gaps", 8'(gaps), 8'd0);
    chk("t3_order_len", 8'(order.size() >= 5), 8'd1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("t3_order", 8'(order[i]), 8'(exp_order[i]));

    // 4: hold-limit preemption of requester 0 by requester 1
    reset_mid(4'b0000);
    cycle(4'b0011);
    for (int k = 0; k < 7; k++) begin
      cycle(4'b0011);
      chk("t4_hold_gnt", 8'(arb_if.gnt), 8'b0001);
    end
    cycle(4'b0011);
    chk("t4_pre_gnt", 8'(arb_if.gnt), 8'b0010);
    chk("t4_pre_pulse", 8'(arb_if.preempt), 8'd1);
    cycle(4'b0011);
    chk("t4_pulse_end", 8'(arb_if.preempt), 8'd0);
    cycle(4'b0001);
    chk("t4_regrant", 8'(arb_if.gnt), 8'b0001);

    // 5: lone long owner never preempted
    reset_mid(4'b0000);
    n_pre = 0;
    for (int k = 0; k < 21; k++) begin
      cycle(4'b1000);
      if (arb_if.preempt) n_pre++;
    end
    chk("t5_gnt", 8'(arb_if.gnt), 8'b1000);
    chk("t5_preempts", 8'(n_pre), 8'd0);

    // 6: async reset mid-grant, then regrant from ptr 0
    reset_mid(4'b0000);
    for (int k = 0; k < 3; k++) cycle(4'b0010);
    chk("t6_pre_gnt", 8'(arb_if.gnt), 8'b0010);
    reset_mid(4'b0010);
    cycle(4'b0010);
    chk("t6_regrant", 8'(arb_if.gnt), 8'b0010);
    chk("t6_ptr", 8'(arb_if.ptr_dbg), 8'd0);

    // random traffic with one mid-run reset
    reset_mid(4'b0000);
    max_wait = 0;
    rnd_req = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (rnd_req[i]) begin
          if ($urandom_range(0, 9) == 0) rnd_req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) rnd_req[i] = 1'b1;
      end
      if (k == 200) reset_mid(rnd_req);
      cycle(rnd_req);
    end
    chk("starvation_bound", 8'(max_wait <= STARVE_BOUND), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
